mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Arbitrates the CPU's single external memory bus between the instruction-fetch requester (driven from the address unit's PC path) and the load/store requester (driven from the address unit's calculated address). It runs one transaction at a time, checks alignment, generates byte enables and store lane replication, aligns load data, and aborts bus cycles that are never acknowledged. It sits between the cpu32e2 core and the system bus.

## Interface
- TIMEOUT, 255: BUS-state cycles without memAck before the transaction aborts; legal range 2..65535.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- fetchReq  in  1  fetch request; held until fetchGnt.
- fetchAddr  in  32  fetch byte address; always a word access.
- fetchGnt  out  1  one-cycle pulse: fetch request accepted.
- fetchRvalid  out  1  one-cycle pulse: fetch complete.
- fetchRdata  out  32  fetched word; valid with fetchRvalid.
- fetchErr  out  1  valid with fetchRvalid: misaligned or timeout.
- lsReq  in  1  load/store request; held until lsGnt.
- lsAddr  in  32  data byte address.
- lsWe  in  1  1 = store, 0 = load.
- lsSize  in  2  00 byte, 01 half, 10 word, 11 reserved.
- lsWdata  in  32  store data, right-justified.
- lsGnt, lsRvalid, lsErr  out  1 each  same meaning as the fetch equivalents.
- lsRdata  out  32  load data, right-justified and zero-extended to size.
- memReq  out  1  bus request; held until memAck or timeout.
- memAddr  out  32  word-aligned address ({addr[31:2],2'b00}).
- memWe  out  1  write strobe qualifier.
- memByteEn  out  4  byte lane enables.
- memWdata  out  32  lane-replicated store data.
- memAck  in  1  one-cycle completion from the bus; memRdata valid with it.
- memRdata  in  32  read data.

## Operation
- FSM states: IDLE, BUS, RESP. Reset: IDLE. All outputs registered. On reset every output is 0, lastOwner = FETCH, and the timeout counter is 0.
- In IDLE, when either request is asserted:
  - Select the owner. If only one request is asserted, that requester wins. If both are asserted, the requester that is not lastOwner wins (round-robin).
  - Pulse that requester's Gnt, update lastOwner, and latch addr, we, size, wdata, and addr[1:0].
- Alignment error cases:
  - lsSize = 11.
  - Half access with addr[0] = 1.
  - Word access, including any fetch, with addr[1:0] != 0.
- On an alignment error, go to RESP with err = 1 and rdata = 0. No bus cycle is issued.
- Otherwise go to BUS. memReq is high throughout BUS.
- memByteEn:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- memWdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Fetches and loads drive memWe = 0.
- In BUS, when memAck is seen: capture memRdata >> (8·addr[1:0]), masked to 8, 16 or 32 bits by size. Drop memReq and go to RESP with err = 0.
- Timeout: the counter clears on entry to BUS and increments on each BUS cycle without memAck. When it reaches TIMEOUT-1 with no memAck, drop memReq and go to RESP with err = 1 and rdata = 0. If memAck arrives in that same cycle, the ack wins.
- RESP lasts one cycle: the owner's Rvalid pulses with its Rdata and Err. The FSM then returns to IDLE. A request present during RESP waits for IDLE.
- Store Rdata is 0. A store still produces Rvalid, which serves as its write-complete.
- A request deasserted before Gnt is ignored and is not an error.
- Reset in any state forces IDLE immediately and drops memReq. An in-flight transaction is lost silently, with no Rvalid.

## Timing
- Gnt is asserted in the cycle after the request is first seen in IDLE. memReq rises in the same cycle as Gnt.
- Ack latency L is the number of cycles from memReq rising to memAck, with L ≥ 1. Rvalid occurs L+1 cycles after Gnt.
- Back-to-back throughput is one transaction per L+3 cycles.
- A misaligned request gets Rvalid exactly 1 cycle after Gnt.
- Timeout: memReq stays high for exactly TIMEOUT cycles. Rvalid with Err follows in the next cycle.
- memAck outside BUS is ignored.

## Test plan
- Single fetch at 0x100, memAck after 3 cycles with 0xDEADBEEF: check fetchGnt, memByteEn = 1111, memAddr = 0x100, fetchRvalid with rdata 0xDEADBEEF and err = 0, 4 cycles after Gnt.
- Simultaneous fetch and ls requests held continuously (lastOwner = FETCH after reset): check the grant order is ls, fetch, ls, fetch, with one transaction per grant.
- Byte store to lsAddr 0x203 with wdata 0x000000A5: check memAddr = 0x200, memByteEn = 1000, memWdata = 0xA5A5A5A5, memWe = 1. Half load from 0x202 with memRdata 0x1234ABCD: check lsRdata = 0x00001234.
- lsSize = 01 at 0x201, and a fetch at 0x102: check that memReq never rises and that Err pulses with Rvalid exactly 1 cycle after Gnt.
- TIMEOUT = 4 with memAck never asserted: check memReq is high for exactly 4 cycles, then Rvalid with Err = 1. Repeat with memAck on the 4th cycle: check Err = 0 and the data is captured.
- Assert reset in the BUS state: check memReq = 0 and all outputs = 0 immediately, with no Rvalid. The next request after reset is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch, load/store and system memory bus signals of the arbiter.
interface mem_bus_arbiter_if;
  logic        fetchReq;
  logic [31:0] fetchAddr;
  logic        fetchGnt;
  logic        fetchRvalid;
  logic [31:0] fetchRdata;
  logic        fetchErr;
  logic        lsReq;
  logic [31:0] lsAddr;
  logic        lsWe;
  logic [1:0]  lsSize;
  logic [31:0] lsWdata;
  logic        lsGnt;
  logic        lsRvalid;
  logic        lsErr;
  logic [31:0] lsRdata;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memWe;
  logic [3:0]  memByteEn;
  logic [31:0] memWdata;
  logic        memAck;
  logic [31:0] memRdata;
  modport master (
    input  fetchReq, fetchAddr, lsReq, lsAddr, lsWe, lsSize, lsWdata, memAck, memRdata,
    output fetchGnt, fetchRvalid, fetchRdata, fetchErr, lsGnt, lsRvalid, lsErr, lsRdata,
           memReq, memAddr, memWe, memByteEn, memWdata
  );
  modport slave (
    output fetchReq, fetchAddr, lsReq, lsAddr, lsWe, lsSize, lsWdata, memAck, memRdata,
    input  fetchGnt, fetchRvalid, fetchRdata, fetchErr, lsGnt, lsRvalid, lsErr, lsRdata,
           memReq, memAddr, memWe, memByteEn, memWdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin fetch/load-store arbiter for the single external memory bus,
// with alignment checking, lane steering, load alignment and bus timeout.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  state_e            state_q, state_d;
  logic              last_q, last_d, own_q, own_d, we_q, we_d, err_q, err_d;
  logic [1:0]        size_q, size_d, off_q, off_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d, rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic [1:0][31:0]  rdata_q, rdata_d;
  logic              req_q, req_d, mwe_q, mwe_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              pick_ls, sel_we, misal;
  logic [31:0]       sel_addr, shifted, load_data;
  logic [1:0]        sel_size;
  // owner encoding: 0 = fetch, 1 = load/store
  assign pick_ls   = bus.lsReq && (!bus.fetchReq || !last_q);
  assign sel_addr  = pick_ls ? bus.lsAddr : bus.fetchAddr;
  assign sel_size  = pick_ls ? bus.lsSize : 2'b10;
  assign sel_we    = pick_ls && bus.lsWe;
  assign misal     = (sel_size == 2'b11) || (sel_size == 2'b01 && sel_addr[0])
                  || (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);
  assign shifted   = bus.memRdata >> {off_q, 3'b000};
  assign load_data = size_q == 2'b00 ? {24'b0, shifted[7:0]}
                   : size_q == 2'b01 ? {16'b0, shifted[15:0]} : shifted;
  // a misaligned grant spends one BUS cycle with memReq low so Rvalid lands one cycle after Gnt
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    own_d    = own_q;
    we_d     = we_q;
    err_d    = err_q;
    size_d   = size_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    rvalid_d = '0;
    rerr_d   = '0;
    rdata_d  = '0;
    req_d    = req_q;
    mwe_d    = mwe_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    if (state_q == IDLE && (bus.fetchReq || bus.lsReq)) begin
      state_d = BUS;
      own_d = pick_ls;
      last_d = pick_ls;
      gnt_d[pick_ls] = 1'b1;
      we_d = sel_we;
      size_d = sel_size;
      off_d = sel_addr[1:0];
      err_d = misal;
      cnt_d = '0;
      req_d = !misal;
      mwe_d = sel_we && !misal;
      addr_d = {sel_addr[31:2], 2'b00};
      be_d = sel_size == 2'b00 ? 4'b0001 << sel_addr[1:0]
           : sel_size == 2'b01 ? 4'b0011 << sel_addr[1:0] : 4'b1111;
      wdata_d = sel_size == 2'b00 ? {4{bus.lsWdata[7:0]}}
              : sel_size == 2'b01 ? {2{bus.lsWdata[15:0]}} : bus.lsWdata;
    end else if (state_q == BUS) begin
      if (err_q || bus.memAck || cnt_q == TO_LAST) begin
        state_d = RESP;
        req_d = 1'b0;
        rvalid_d[own_q] = 1'b1;
        rerr_d[own_q] = err_q || !bus.memAck;
        rdata_d[own_q] = (err_q || we_q || !bus.memAck) ? '0 : load_data;
      end else cnt_d = cnt_q + 16'd1;
    end else if (state_q == RESP) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b0;
      own_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= '0;
      off_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rerr_q   <= '0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      mwe_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      own_q    <= own_d;
      we_q     <= we_d;
      err_q    <= err_d;
      size_q   <= size_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      mwe_q    <= mwe_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end
  assign bus.fetchGnt    = gnt_q[0];
  assign bus.lsGnt       = gnt_q[1];
  assign bus.fetchRvalid = rvalid_q[0];
  assign bus.lsRvalid    = rvalid_q[1];
  assign bus.fetchErr    = rerr_q[0];
  assign bus.lsErr       = rerr_q[1];
  assign bus.fetchRdata  = rdata_q[0];
  assign bus.lsRdata     = rdata_q[1];
  assign bus.memReq      = req_q;
  assign bus.memWe       = mwe_q;
  assign bus.memAddr     = addr_q;
  assign bus.memWdata    = wdata_q;
  assign bus.memByteEn   = be_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vector table plus hand-written sequences for round-robin,
// timeout and mid-transaction reset.
module tb_mem_bus_arbiter;
  logic clk, reset;
  int tests, fails;
  mem_bus_arbiter_if bus();
  mem_bus_arbiter #(.TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic        ls;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          lat;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic        err;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs [12];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic void check(string n, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endfunction
  task automatic run_vec(input vec_t v);
    bus.fetchReq = !v.ls;
    bus.lsReq = v.ls;
    bus.fetchAddr = v.addr;
    bus.lsAddr = v.addr;
    bus.lsWe = v.we;
    bus.lsSize = v.size;
    bus.lsWdata = v.wdata;
    step();
    check("gnt", {30'b0, bus.lsGnt, bus.fetchGnt}, v.ls ? 32'd2 : 32'd1);
    bus.fetchReq = 1'b0;
    bus.lsReq = 1'b0;
    check("memReq_rise", {31'b0, bus.memReq}, {31'b0, !v.err});
    if (v.err) begin
      bus.memAck = 1'b1;
      bus.memRdata = 32'hFFFFFFFF;
    end else begin
      check("memAddr", bus.memAddr, {v.addr[31:2], 2'b00});
      check("memByteEn", {28'b0, bus.memByteEn}, {28'b0, v.be});
      check("memWe", {31'b0, bus.memWe}, {31'b0, v.we});
      if (v.we) check("memWdata", bus.memWdata, v.mwd);
      for (int i = 0; i < v.lat; i++) step();
      check("memReq_hold", {31'b0, bus.memReq}, 32'd1);
      bus.memAck = 1'b1;
      bus.memRdata = v.rd;
    end
    step();
    bus.memAck = 1'b0;
    check("rvalid", {30'b0, bus.lsRvalid, bus.fetchRvalid}, v.ls ? 32'd2 : 32'd1);
    check("err", {31'b0, v.ls ? bus.lsErr : bus.fetchErr}, {31'b0, v.err});
    check("rdata", v.ls ? bus.lsRdata : bus.fetchRdata, v.rdata);
    check("memReq_drop", {31'b0, bus.memReq}, 32'd0);
    step();
    check("rvalid_end", {30'b0, bus.lsRvalid, bus.fetchRvalid}, 32'd0);
  endtask
  task automatic run_timeout(input logic ls, input logic [31:0] addr, input int ack_at,
                             input logic exp_err, input logic [31:0] exp_rd);
    int hi, rv;
    logic er;
    logic [31:0] rd;
    hi = 0; rv = 0; er = 1'b0; rd = '0;
    bus.fetchReq = !ls;
    bus.lsReq = ls;
    bus.fetchAddr = addr;
    bus.lsAddr = addr;
    bus.lsWe = 1'b0;
    bus.lsSize = 2'b10;
    step();
    bus.fetchReq = 1'b0;
    bus.lsReq = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (bus.memReq) hi++;
      if (ls ? bus.lsRvalid : bus.fetchRvalid) begin
        rv = i;
        er = ls ? bus.lsErr : bus.fetchErr;
        rd = ls ? bus.lsRdata : bus.fetchRdata;
      end
      bus.memAck = (i == ack_at);
      bus.memRdata = 32'h0BADF00D;
      step();
    end
    bus.memAck = 1'b0;
    check("to_memReq_cycles", hi, 32'd4);
    check("to_rvalid_cycle", rv, 32'd5);
    check("to_err", {31'b0, er}, {31'b0, exp_err});
    check("to_rdata", rd, exp_rd);
  endtask
  int busc, ng, nf, nl;
  logic order [4];
  int gcyc [4];
  initial begin
    tests = 0; fails = 0;
    vecs[0]  = '{1'b0, 1'b0, 2'b10, 32'h100, 32'h0,        32'hDEADBEEF, 3, 4'b1111, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b1, 2'b00, 32'h203, 32'h000000A5, 32'h55555555, 1, 4'b1000, 32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 2'b01, 32'h202, 32'h0,        32'h1234ABCD, 2, 4'b1100, 32'h0,        1'b0, 32'h00001234};
    vecs[3]  = '{1'b1, 1'b0, 2'b01, 32'h201, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        1'b1, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 2'b10, 32'h102, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 32'h101, 32'h0,        32'h11223344, 1, 4'b0010, 32'h0,        1'b0, 32'h00000033};
    vecs[6]  = '{1'b1, 1'b1, 2'b01, 32'h300, 32'hFFFF5678, 32'h55555555, 2, 4'b0011, 32'h56785678, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 2'b10, 32'h400, 32'h0,        32'hCAFEF00D, 1, 4'b1111, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 1'b0, 2'b11, 32'h400, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        1'b1, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 2'b10, 32'h402, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 2'b10, 32'h500, 32'h89ABCDEF, 32'h55555555, 1, 4'b1111, 32'h89ABCDEF, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 32'h003, 32'h0,        32'hA1B2C3D4, 2, 4'b1000, 32'h0,        1'b0, 32'h000000A1};
    reset = 1'b1;
    bus.fetchReq = 1'b0; bus.fetchAddr = '0; bus.lsReq = 1'b0; bus.lsAddr = '0;
    bus.lsWe = 1'b0; bus.lsSize = '0; bus.lsWdata = '0; bus.memAck = 1'b0; bus.memRdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_ctrl", {26'b0, bus.fetchGnt, bus.lsGnt, bus.fetchRvalid, bus.lsRvalid, bus.memReq, bus.memWe}, 32'd0);
    check("reset_data", bus.memAddr | bus.memWdata | {28'b0, bus.memByteEn} | bus.fetchRdata | bus.lsRdata, 32'd0);
    check("reset_err", {30'b0, bus.fetchErr, bus.lsErr}, 32'd0);
    step();
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);
    run_timeout(1'b0, 32'h800, 0, 1'b1, 32'h0);
    step();
    run_timeout(1'b1, 32'h900, 4, 1'b0, 32'h0BADF00D);
    step();
    bus.fetchReq = 1'b1;
    bus.fetchAddr = 32'hA00;
    step();
    bus.fetchReq = 1'b0;
    check("rst_gnt", {31'b0, bus.fetchGnt}, 32'd1);
    step();
    check("rst_in_bus", {31'b0, bus.memReq}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_ctrl", {26'b0, bus.fetchGnt, bus.lsGnt, bus.fetchRvalid, bus.lsRvalid, bus.memReq, bus.memWe}, 32'd0);
    check("rst_async_data", bus.memAddr | bus.memWdata | {28'b0, bus.memByteEn} | bus.fetchRdata | bus.lsRdata, 32'd0);
    step();
    reset = 1'b0;
    bus.memAck = 1'b1;
    nf = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      bus.memAck = 1'b0;
      nf += int'(bus.fetchRvalid) + int'(bus.lsRvalid) + int'(bus.memReq);
    end
    check("rst_no_rvalid", nf, 32'd0);
    vecs[0].addr = 32'h104;
    vecs[0].rd = 32'h600DCAFE;
    vecs[0].rdata = 32'h600DCAFE;
    vecs[0].lat = 1;
    run_vec(vecs[0]);
    bus.fetchAddr = 32'h700; bus.lsAddr = 32'h600; bus.lsWe = 1'b0; bus.lsSize = 2'b10;
    bus.memRdata = 32'h12345678;
    bus.fetchReq = 1'b1; bus.lsReq = 1'b1;
    busc = 0; ng = 0; nf = 0; nl = 0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (bus.fetchGnt && bus.lsGnt) check("rr_double_gnt", 32'd1, 32'd0);
      if (bus.fetchGnt || bus.lsGnt) begin
        if (ng < 4) begin
          order[ng] = bus.lsGnt;
          gcyc[ng] = c;
        end
        ng++;
        if (ng == 4) begin
          bus.fetchReq = 1'b0;
          bus.lsReq = 1'b0;
        end
      end
      nf += int'(bus.fetchRvalid);
      nl += int'(bus.lsRvalid);
      if (bus.memReq) begin
        busc++;
        bus.memAck = (busc == 2);
      end else begin
        busc = 0;
        bus.memAck = 1'b0;
      end
    end
    check("rr_grants", ng, 32'd4);
    if (ng >= 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), {31'b0, order[i]}, (i % 2 == 0) ? 32'd1 : 32'd0);
      for (int i = 1; i < 4; i++) check($sformatf("rr_period%0d", i), gcyc[i] - gcyc[i-1], 32'd4);
    end
    check("rr_fetch_rvalids", nf, 32'd2);
    check("rr_ls_rvalids", nl, 32'd2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
